// File: rtl/key_pkg.sv
// Shared state encodings for the key filter / key event decoder family.
package key_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_PRESS1 = 3'd1,
        ST_WAIT2  = 3'd2,
        ST_PRESS2 = 3'd3,
        ST_HOLD   = 3'd4
    } key_state_e;

endpackage

// File: rtl/key_evt_timer.sv
// Saturating gesture timer with synchronous clear and a terminal-count compare
// against a limit that may change at runtime.
module key_evt_timer #(
    parameter int unsigned CNT_W = 32
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_clr,
    input  logic             i_en,
    input  logic [CNT_W-1:0] i_limit,
    output logic             o_tc
);

    localparam logic [CNT_W-1:0] LP_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [CNT_W-1:0] r_cnt;

    assign o_tc = (r_cnt == (i_limit - LP_ONE));

    // Holding at the terminal count keeps the timer from ever wrapping.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_en && !o_tc) begin
            r_cnt <= r_cnt + LP_ONE;
        end
    end

endmodule

// File: rtl/key_event_decoder.sv
// Turns the debounced key stream into short-press, double-click and
// long-press pulses. Key is active-low.
import key_pkg::*;

module key_event_decoder #(
    parameter int unsigned LONG_CNT    = 50_000_000,
    parameter int unsigned DBL_GAP_CNT = 12_500_000,
    parameter int unsigned CNT_W       = 32
) (
    input  logic sys_clk,
    input  logic sys_rst_n,
    input  logic key_flag,
    input  logic key_value,
    output logic short_press,
    output logic double_click,
    output logic long_press,
    output logic busy
);

    localparam logic [CNT_W-1:0] LP_LONG = CNT_W'(LONG_CNT);
    localparam logic [CNT_W-1:0] LP_GAP  = CNT_W'(DBL_GAP_CNT);

    key_state_e       r_state;
    logic             w_press;
    logic             w_release;
    logic             w_tc;
    logic             w_timed;
    logic             w_chg;
    logic [CNT_W-1:0] w_limit;

    assign w_press   = key_flag & ~key_value;
    assign w_release = key_flag & key_value;

    assign w_timed = (r_state == ST_PRESS1) ||
                     (r_state == ST_WAIT2)  ||
                     (r_state == ST_PRESS2);
    assign w_limit = (r_state == ST_WAIT2) ? LP_GAP : LP_LONG;

    // Restart the timer on exactly the edges where the FSM leaves its state.
    always_comb begin
        w_chg = 1'b0;
        case (r_state)
            ST_IDLE:   w_chg = w_press;
            ST_PRESS1: w_chg = w_release | w_tc;
            ST_WAIT2:  w_chg = w_press | w_tc;
            ST_PRESS2: w_chg = w_release | w_tc;
            ST_HOLD:   w_chg = w_release;
            default:   w_chg = 1'b1;
        endcase
    end

    key_evt_timer #(
        .CNT_W (CNT_W)
    ) u_timer (
        .i_clk   (sys_clk),
        .i_rst_n (sys_rst_n),
        .i_clr   (w_chg),
        .i_en    (w_timed),
        .i_limit (w_limit),
        .o_tc    (w_tc)
    );

    // Key events are tested before the timeout so they win on the terminal count.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_state      <= ST_IDLE;
            short_press  <= 1'b0;
            double_click <= 1'b0;
            long_press   <= 1'b0;
            busy         <= 1'b0;
        end else begin
            short_press  <= 1'b0;
            double_click <= 1'b0;
            long_press   <= 1'b0;
            busy         <= (r_state != ST_IDLE);
            case (r_state)
                ST_IDLE: begin
                    if (w_press) r_state <= ST_PRESS1;
                end
                ST_PRESS1: begin
                    if (w_release) begin
                        r_state <= ST_WAIT2;
                    end else if (w_tc) begin
                        long_press <= 1'b1;
                        r_state    <= ST_HOLD;
                    end
                end
                ST_WAIT2: begin
                    if (w_press) begin
                        r_state <= ST_PRESS2;
                    end else if (w_tc) begin
                        short_press <= 1'b1;
                        r_state     <= ST_IDLE;
                    end
                end
                ST_PRESS2: begin
                    if (w_release) begin
                        double_click <= 1'b1;
                        r_state      <= ST_IDLE;
                    end else if (w_tc) begin
                        double_click <= 1'b1;
                        r_state      <= ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    if (w_release) r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_key_event_decoder.sv
// Bench for key_event_decoder: directed gestures plus random key traffic
// against a timestamp-based gesture model.
module tb_key_event_decoder;

    localparam int LONG = 20;
    localparam int GAP  = 10;

    logic sys_clk;
    logic sys_rst_n;
    logic key_flag;
    logic key_value;
    logic short_press;
    logic double_click;
    logic long_press;
    logic busy;

    int errs;
    int nchk;

    // Gesture model: phase of the gesture and the cycle it began.
    // 0 idle, 1 first press, 2 gap, 3 second press, 4 hold
    int m_phase;
    int m_since;
    int cyc;

    key_event_decoder #(
        .LONG_CNT    (LONG),
        .DBL_GAP_CNT (GAP),
        .CNT_W       (32)
    ) dut (
        .sys_clk      (sys_clk),
        .sys_rst_n    (sys_rst_n),
        .key_flag     (key_flag),
        .key_value    (key_value),
        .short_press  (short_press),
        .double_click (double_click),
        .long_press   (long_press),
        .busy         (busy)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    task automatic chk(input string tag, input logic obs, input logic exp);
        nchk++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s obs=%b exp=%b cyc=%0d", tag, obs, exp, cyc);
        end
    endtask

    task automatic tick(input logic f, input logic v);
        int   el;
        int   nxt;
        logic pr;
        logic rl;
        logic e_sp;
        logic e_dc;
        logic e_lp;
        logic e_bz;
        key_flag  = f;
        key_value = v;
        cyc++;
        el   = cyc - m_since;
        pr   = f & ~v;
        rl   = f & v;
        e_bz = (m_phase != 0);
        e_sp = 1'b0;
        e_dc = 1'b0;
        e_lp = 1'b0;
        nxt  = m_phase;
        case (m_phase)
            0: if (pr) nxt = 1;
            1: begin
                if (rl) nxt = 2;
                else if (el == LONG) begin e_lp = 1'b1; nxt = 4; end
            end
            2: begin
                if (pr) nxt = 3;
                else if (el == GAP) begin e_sp = 1'b1; nxt = 0; end
            end
            3: begin
                if (rl) begin e_dc = 1'b1; nxt = 0; end
                else if (el == LONG) begin e_dc = 1'b1; nxt = 4; end
            end
            default: if (rl) nxt = 0;
        endcase
        if (nxt != m_phase) m_since = cyc;
        m_phase = nxt;
        @(posedge sys_clk);
        #1;
        key_flag = 1'b0;
        chk("short_press", short_press, e_sp);
        chk("double_click", double_click, e_dc);
        chk("long_press", long_press, e_lp);
        chk("busy", busy, e_bz);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(1'b0, 1'b1);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_sp"}, short_press, 1'b0);
        chk({tag, "_dc"}, double_click, 1'b0);
        chk({tag, "_lp"}, long_press, 1'b0);
        chk({tag, "_busy"}, busy, 1'b0);
    endtask

    initial begin
        errs      = 0;
        nchk      = 0;
        cyc       = 0;
        m_phase   = 0;
        m_since   = 0;
        key_flag  = 1'b0;
        key_value = 1'b1;
        sys_rst_n = 1'b0;
        repeat (3) @(posedge sys_clk);
        #1;
        chk_all_zero("reset");
        sys_rst_n = 1'b1;
        idle(3);

        // single click
        tick(1'b1, 1'b0);
        idle(4);
        tick(1'b1, 1'b1);
        idle(14);

        // double click
        tick(1'b1, 1'b0);
        idle(4);
        tick(1'b1, 1'b1);
        idle(3);
        tick(1'b1, 1'b0);
        idle(2);
        tick(1'b1, 1'b1);
        idle(12);

        // long press then release
        tick(1'b1, 1'b0);
        idle(24);
        tick(1'b1, 1'b1);
        idle(4);

        // events on the terminal counts win over the timeouts
        tick(1'b1, 1'b0);
        idle(19);
        tick(1'b1, 1'b1);
        idle(9);
        tick(1'b1, 1'b0);
        idle(3);
        tick(1'b1, 1'b1);
        idle(12);

        // second press held into hold
        tick(1'b1, 1'b0);
        tick(1'b1, 1'b1);
        tick(1'b1, 1'b0);
        idle(25);
        tick(1'b1, 1'b1);
        idle(3);

        // reset during the gap
        tick(1'b1, 1'b0);
        idle(2);
        tick(1'b1, 1'b1);
        idle(4);
        #1;
        sys_rst_n = 1'b0;
        #1;
        chk_all_zero("midrst");
        m_phase = 0;
        m_since = cyc;
        #2;
        sys_rst_n = 1'b1;
        idle(15);

        // mismatched events are ignored
        tick(1'b1, 1'b1);
        idle(2);
        tick(1'b1, 1'b0);
        idle(3);
        tick(1'b1, 1'b0);
        idle(3);
        tick(1'b1, 1'b1);
        idle(12);

        // random key traffic
        for (int k = 0; k < 200; k++) begin
            idle($urandom_range(0, 24));
            tick(1'b1, 1'($urandom_range(0, 1)));
        end
        idle(30);

        $display("Result: errors=%0d of %0d checks", errs, nchk);
        $finish;
    end

endmodule
